// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared word width, sample type and deserializer state encoding
package msdap_pkg;
   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] sample_t;

   typedef enum logic {
      DS_IDLE,
      DS_SHIFT
   } deser_state_t;
endpackage

// File: rtl/msdap_shift_in.sv
// rtl/msdap_shift_in.sv - per-channel MSB-first shift register with restart
module msdap_shift_in #(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              shift,
   input  logic              restart,
   input  logic              din,
   output logic [WORD_W-1:0] word
);
   // Only WORD_W-1 bits are stored: the final bit is taken straight from din
   // on the completing tick, so the top loads the full word on that same edge.
   logic [WORD_W-2:0] sr;

   assign word = {sr, din};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (clear) begin
         sr <= '0;
      end else if (restart) begin
         sr <= {{(WORD_W-2){1'b0}}, din};
      end else if (shift) begin
         sr <= word[WORD_W-2:0];
      end
   end
endmodule

// File: rtl/msdap_serial_deserializer.sv
// rtl/msdap_serial_deserializer.sv - stereo serial-to-parallel word deserializer with valid/ready output
// Optional sample index counter and port: define MSDAP_SAMPLE_CNT_EN.
module msdap_serial_deserializer
   import msdap_pkg::*;
#(
   parameter int WORD_W = msdap_pkg::WORD_W
`ifdef MSDAP_SAMPLE_CNT_EN
   , parameter int SAMPLE_CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              bit_tick,
   input  logic              frame,
   input  logic              in_l,
   input  logic              in_r,
   output logic [WORD_W-1:0] data_l,
   output logic [WORD_W-1:0] data_r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun
`ifdef MSDAP_SAMPLE_CNT_EN
   , output logic [SAMPLE_CNT_W-1:0] sample_idx
`endif
);
   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

   deser_state_t      state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] word_l;
   logic [WORD_W-1:0] word_r;
   logic              restart;
   logic              shift_en;
   logic              last_bit;

   // A framed tick always starts a fresh word, whatever the current state.
   assign restart  = bit_tick && frame;
   assign shift_en = bit_tick && !frame && (state == DS_SHIFT);
   assign last_bit = shift_en && (bit_cnt == LAST_CNT);

   msdap_shift_in #(.WORD_W(WORD_W)) u_shift_l (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .shift   (shift_en),
      .restart (restart),
      .din     (in_l),
      .word    (word_l)
   );

   msdap_shift_in #(.WORD_W(WORD_W)) u_shift_r (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .shift   (shift_en),
      .restart (restart),
      .din     (in_r),
      .word    (word_r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= DS_IDLE;
         bit_cnt   <= '0;
         data_l    <= '0;
         data_r    <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else if (clear) begin
         state     <= DS_IDLE;
         bit_cnt   <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (restart) begin
            if (state == DS_SHIFT) begin
               frame_err <= 1'b1;
            end
            state   <= DS_SHIFT;
            bit_cnt <= CNT_W'(1);
         end else if (last_bit) begin
            state   <= DS_IDLE;
            bit_cnt <= '0;
            // Slot is free if empty or being drained this very cycle.
            if (!out_valid || out_ready) begin
               data_l    <= word_l;
               data_r    <= word_r;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

`ifdef MSDAP_SAMPLE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_idx <= '0;
      end else if (clear) begin
         sample_idx <= '0;
      end else if (out_valid && out_ready) begin
         sample_idx <= sample_idx + SAMPLE_CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_msdap_serial_deserializer.sv
// tb/tb_msdap_serial_deserializer.sv - directed table-driven bench for the serial deserializer
module tb_msdap_serial_deserializer;
   import msdap_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n = 1'b0;
   logic    clear = 1'b0;
   logic    bit_tick = 1'b0;
   logic    frame = 1'b0;
   logic    in_l = 1'b0;
   logic    in_r = 1'b0;
   logic    out_ready = 1'b0;
   sample_t data_l;
   sample_t data_r;
   logic    out_valid;
   logic    frame_err;
   logic    overrun;
`ifdef MSDAP_SAMPLE_CNT_EN
   logic [15:0] sample_idx;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      sample_t l;
      sample_t r;
      sample_t exp_l;
      sample_t exp_r;
   } vec_t;

   vec_t vecs [4];

   msdap_serial_deserializer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .bit_tick  (bit_tick),
      .frame     (frame),
      .in_l      (in_l),
      .in_r      (in_r),
      .data_l    (data_l),
      .data_r    (data_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef MSDAP_SAMPLE_CNT_EN
      , .sample_idx (sample_idx)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic l, input logic r, input logic f);
      bit_tick = 1'b1;
      frame    = f;
      in_l     = l;
      in_r     = r;
      @(posedge clk);
      #1;
      bit_tick = 1'b0;
      frame    = 1'b0;
   endtask

   task automatic send_word(input sample_t l, input sample_t r);
      for (int i = WORD_W - 1; i >= 0; i--) begin
         idle();
         tick(l[i], r[i], i == WORD_W - 1);
      end
   endtask

   initial begin
      vecs[0] = '{l: 16'hA5C3, r: 16'h1234, exp_l: 16'hA5C3, exp_r: 16'h1234};
      vecs[1] = '{l: 16'hFFFF, r: 16'h0000, exp_l: 16'hFFFF, exp_r: 16'h0000};
      vecs[2] = '{l: 16'h0001, r: 16'h8000, exp_l: 16'h0001, exp_r: 16'h8000};
      vecs[3] = '{l: 16'h00FF, r: 16'hFF00, exp_l: 16'h00FF, exp_r: 16'hFF00};

      idle();
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_data_l", 32'(data_l), 32'd0);
      check("reset_data_r", 32'(data_r), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      idle();

      out_ready = 1'b1;
      foreach (vecs[k]) begin
         send_word(vecs[k].l, vecs[k].r);
         check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("vec%0d_data_l", k), 32'(data_l), 32'(vecs[k].exp_l));
         check($sformatf("vec%0d_data_r", k), 32'(data_r), 32'(vecs[k].exp_r));
         idle();
         check($sformatf("vec%0d_accepted", k), 32'(out_valid), 32'd0);
      end
`ifdef MSDAP_SAMPLE_CNT_EN
      check("sample_idx_after_table", 32'(sample_idx), 32'd4);
`endif

      // Overrun: second word arrives while first is still held.
      out_ready = 1'b0;
      send_word(16'h1111, 16'h2222);
      check("ovr_first_valid", 32'(out_valid), 32'd1);
      check("ovr_first_no_overrun", 32'(overrun), 32'd0);
      send_word(16'h3333, 16'h4444);
      check("ovr_held_l", 32'(data_l), 32'h1111);
      check("ovr_held_r", 32'(data_r), 32'h2222);
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_still_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
      check("ovr_drained", 32'(out_valid), 32'd0);
      check("ovr_sticky", 32'(overrun), 32'd1);
      clear = 1'b1;
      idle();
      clear = 1'b0;
      check("clear_overrun", 32'(overrun), 32'd0);
      check("clear_keeps_data", 32'(data_l), 32'h1111);
`ifdef MSDAP_SAMPLE_CNT_EN
      check("clear_sample_idx", 32'(sample_idx), 32'd0);
`endif

      // Completion coinciding with acceptance of the previous word.
      send_word(16'hAAAA, 16'h5555);
      check("swap_first_valid", 32'(out_valid), 32'd1);
      for (int i = WORD_W - 1; i >= 0; i--) begin
         idle();
         if (i == 0) out_ready = 1'b1;
         tick(sample_t'(16'h00FF) >> i, sample_t'(16'hFF00) >> i, i == WORD_W - 1);
      end
      out_ready = 1'b0;
      check("swap_valid", 32'(out_valid), 32'd1);
      check("swap_data_l", 32'(data_l), 32'h00FF);
      check("swap_data_r", 32'(data_r), 32'hFF00);
      check("swap_no_overrun", 32'(overrun), 32'd0);
      out_ready = 1'b1;
      idle();
      check("swap_drained", 32'(out_valid), 32'd0);

      // Frame arriving after 7 bits restarts the word.
      for (int i = 0; i < 7; i++) begin
         idle();
         tick(1'b1, 1'b0, i == 0);
      end
      check("ferr_before", 32'(frame_err), 32'd0);
      send_word(16'hBEEF, 16'hCAFE);
      check("ferr_flag", 32'(frame_err), 32'd1);
      check("ferr_valid", 32'(out_valid), 32'd1);
      check("ferr_data_l", 32'(data_l), 32'hBEEF);
      check("ferr_data_r", 32'(data_r), 32'hCAFE);
      idle();

      // Async reset in the middle of a word.
      for (int i = 0; i < 9; i++) begin
         idle();
         tick(1'b1, 1'b1, i == 0);
      end
      rst_n = 1'b0;
      #1;
      check("arst_data_l", 32'(data_l), 32'd0);
      check("arst_data_r", 32'(data_r), 32'd0);
      check("arst_frame_err", 32'(frame_err), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      idle();
      rst_n = 1'b1;
      idle();
      tick(1'b1, 1'b1, 1'b0);
      idle();
      tick(1'b1, 1'b1, 1'b0);
      check("unframed_ignored", 32'(out_valid), 32'd0);
      send_word(16'h0F0F, 16'hF0F0);
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_data_l", 32'(data_l), 32'h0F0F);
      check("post_rst_data_r", 32'(data_r), 32'hF0F0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
